// File: rtl/pulse_event_queue.sv
// Counts rising edges on i_iSig and re-issues them as single-cycle pulses spaced
// GAP clocks apart, so a downstream pulse synchronizer never drops an event.
module pulse_event_queue #(
  parameter int CNT_W = 8,
  parameter int GAP   = 8
) (
  input  logic             i_IClk,
  input  logic             i_IReset,
  input  logic             i_iSig,
  input  logic             i_iClrOvf,
  output logic             o_iPulse,
  output logic [CNT_W-1:0] o_iPending,
  output logic             o_iBusy,
  output logic             o_iOverflow
);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT} state_t;

  localparam logic [7:0]       GAP_LOAD = 8'(GAP - 2);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t           state_reg, state_next;
  logic [7:0]       gap_reg, gap_next;
  logic [CNT_W-1:0] pending_reg, pending_next;
  logic             prev_reg;
  logic             ovf_reg, ovf_next;
  logic             event_w, dec_w;

  assign event_w = i_iSig & ~prev_reg;
  assign dec_w   = (state_reg == FIRE);

  always_ff @(posedge i_IClk) begin
    if (i_IReset) begin
      state_reg   <= IDLE;
      gap_reg     <= '0;
      pending_reg <= '0;
      prev_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gap_reg     <= gap_next;
      pending_reg <= pending_next;
      prev_reg    <= i_iSig;
      ovf_reg     <= ovf_next;
    end
  end

  // Next state and gap counter; decisions use the registered backlog only.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: if (pending_reg != '0) state_next = FIRE;
      FIRE: begin
        gap_next   = GAP_LOAD;
        state_next = WAIT;
      end
      WAIT: begin
        if (gap_reg != '0) begin
          gap_next = gap_reg - 8'd1;
        end else if (pending_reg != '0) begin
          state_next = FIRE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Backlog counter; a saturated increment is dropped and recorded as overflow.
  always_comb begin
    pending_next = pending_reg;
    ovf_next     = ovf_reg & ~i_iClrOvf;
    if (event_w && !dec_w) begin
      if (pending_reg == PEND_MAX) begin
        ovf_next = 1'b1;
      end else begin
        pending_next = pending_reg + 1'b1;
      end
    end else if (!event_w && dec_w) begin
      pending_next = pending_reg - 1'b1;
    end
  end

  always_comb begin
    o_iPulse    = (state_reg == FIRE);
    o_iBusy     = (state_reg != IDLE) || (pending_reg != '0);
    o_iPending  = pending_reg;
    o_iOverflow = ovf_reg;
  end

endmodule

// File: tb/tb_pulse_event_queue.sv
// Drives three differently-parameterised queues with the same event stream and
// compares each against a timing model built from last-pulse times and backlog counts.
module tb_pulse_event_queue;

  logic       clk = 1'b0;
  logic       rst, sig, clr;
  logic [2:0] pulse, busy, ovf;
  logic [7:0] pend0;
  logic [2:0] pend1;
  logic [3:0] pend2;

  int checks = 0;
  int errors = 0;
  int n = 0;

  int gap_p[3] = '{8, 8, 2};
  int max_p[3] = '{255, 7, 15};
  int m_pend[3], m_fire[3], m_ovf[3], m_last[3], m_has[3];
  int m_prev;

  always #5 clk = ~clk;

  pulse_event_queue #(.CNT_W(8), .GAP(8)) dut0 (
    .i_IClk(clk), .i_IReset(rst), .i_iSig(sig), .i_iClrOvf(clr),
    .o_iPulse(pulse[0]), .o_iPending(pend0), .o_iBusy(busy[0]), .o_iOverflow(ovf[0]));
  pulse_event_queue #(.CNT_W(3), .GAP(8)) dut1 (
    .i_IClk(clk), .i_IReset(rst), .i_iSig(sig), .i_iClrOvf(clr),
    .o_iPulse(pulse[1]), .o_iPending(pend1), .o_iBusy(busy[1]), .o_iOverflow(ovf[1]));
  pulse_event_queue #(.CNT_W(4), .GAP(2)) dut2 (
    .i_IClk(clk), .i_IReset(rst), .i_iSig(sig), .i_iClrOvf(clr),
    .o_iPulse(pulse[2]), .o_iPending(pend2), .o_iBusy(busy[2]), .o_iOverflow(ovf[2]));

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] cycle %0d observed %0d expected %0d", tag, idx, n, obs, exp);
    end
  endtask

  // Event model: a pulse may issue once the backlog is non-zero and at least
  // GAP cycles have elapsed since the previous pulse.
  task automatic model_update(input logic s, input logic c, input logic r);
    int ev, np, set, nf;
    ev = (s && m_prev == 0) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_pend[i] = 0; m_fire[i] = 0; m_ovf[i] = 0; m_has[i] = 0;
      end else begin
        nf  = (m_pend[i] != 0 && (m_has[i] == 0 || n - m_last[i] >= gap_p[i])) ? 1 : 0;
        np  = m_pend[i];
        set = 0;
        if (ev == 1 && m_fire[i] == 0) begin
          if (np == max_p[i]) set = 1;
          else np++;
        end else if (ev == 0 && m_fire[i] == 1) begin
          np--;
        end
        m_ovf[i]  = (set == 1 || (m_ovf[i] == 1 && !c)) ? 1 : 0;
        m_pend[i] = np;
        m_fire[i] = nf;
        if (nf == 1) begin
          m_last[i] = n;
          m_has[i]  = 1;
        end
      end
    end
    m_prev = (r || !s) ? 0 : 1;
  endtask

  task automatic step(input logic s, input logic c, input logic r);
    int exp_busy;
    logic [31:0] pend_obs[3];
    sig = s; clr = c; rst = r;
    @(posedge clk);
    n++;
    model_update(s, c, r);
    @(negedge clk);
    pend_obs[0] = 32'(pend0);
    pend_obs[1] = 32'(pend1);
    pend_obs[2] = 32'(pend2);
    for (int i = 0; i < 3; i++) begin
      exp_busy = (m_pend[i] != 0 || (m_has[i] == 1 && n - m_last[i] < gap_p[i])) ? 1 : 0;
      chk("pulse", i, 32'(pulse[i]), 32'(m_fire[i]));
      chk("pending", i, pend_obs[i], 32'(m_pend[i]));
      chk("busy", i, 32'(busy[i]), 32'(exp_busy));
      chk("overflow", i, 32'(ovf[i]), 32'(m_ovf[i]));
    end
    $display("cycle %0d sig=%0b clr=%0b rst=%0b pulse=%b pend=%0d/%0d/%0d busy=%b ovf=%b",
             n, s, c, r, pulse, pend0, pend1, pend2, busy, ovf);
  endtask

  initial begin
    m_prev = 0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; m_fire[i] = 0; m_ovf[i] = 0; m_last[i] = 0; m_has[i] = 0;
    end
    sig = 1'b0; clr = 1'b0; rst = 1'b1;

    step(0, 0, 1);
    step(0, 0, 1);
    n = 0;
    // Single event at edge 10, then drain.
    while (n < 9) step(0, 0, 0);
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    // Three events two cycles apart.
    repeat (3) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    repeat (30) step(0, 0, 0);
    // Long level is a single event.
    repeat (40) step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    // Saturate the narrow counter.
    repeat (12) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    // Reset with a backlog in flight, then check quiet afterward.
    repeat (6) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    step(0, 0, 1);
    repeat (15) step(0, 0, 0);
    // Reset release with input already high counts as an edge.
    step(1, 0, 1);
    repeat (5) step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    // Random traffic: dense, then sparse.
    repeat (250) step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0),
                      logic'($urandom_range(0, 99) == 0));
    repeat (250) step(logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 15) == 0),
                      logic'($urandom_range(0, 149) == 0));
    repeat (300) step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
